// File: rtl/rll_key_loader.sv
// Serial key loader: receives a framed key (KEY_WIDTH bits MSB first plus an even-parity
// bit), checks it and applies it in parallel on key_out. An optional seal blocks reloads
// until zeroize or reset.
module rll_key_loader #(
  parameter int unsigned KEY_WIDTH    = 16,
  parameter int unsigned TIMEOUT      = 255,
  parameter bit          SEAL_ON_LOAD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 zeroize,
  input  logic                 load_start,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  output logic                 ready,
  output logic                 busy,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 sealed,
  output logic                 parity_err,
  output logic                 timeout_err
);

  localparam int unsigned CntW  = $clog2(KEY_WIDTH + 1);
  localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IdleW-1:0]     idle_cnt_q, idle_cnt_d;
  logic                 valid_q, valid_d;
  logic                 sealed_q, sealed_d;
  logic                 perr_q, perr_d;
  logic                 terr_q, terr_d;
  logic                 start_ok;

  // A restart mid-frame is always honoured; a fresh frame only when not sealed.
  assign start_ok = load_start && ((state_q != StIdle) || !sealed_q);

  // Next-state logic: zeroize beats load_start, which beats bit_valid.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    key_d      = key_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    valid_d    = valid_q;
    sealed_d   = sealed_q;
    perr_d     = 1'b0;
    terr_d     = 1'b0;
    if (zeroize) begin
      state_d    = StIdle;
      key_d      = '0;
      valid_d    = 1'b0;
      sealed_d   = 1'b0;
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
    end else if (start_ok) begin
      state_d    = StShift;
      shadow_d   = '0;
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StShift, StParity: begin
          if (bit_valid) begin
            idle_cnt_d = '0;
            if (state_q == StShift) begin
              shadow_d  = {shadow_q[KEY_WIDTH-2:0], bit_data};
              bit_cnt_d = bit_cnt_q + 1'b1;
              if (bit_cnt_q == CntW'(KEY_WIDTH - 1)) begin
                state_d = StParity;
              end
            end else begin
              state_d = StIdle;
              // Even parity over key plus parity bit.
              if (bit_data == ^shadow_q) begin
                key_d    = shadow_q;
                valid_d  = 1'b1;
                sealed_d = SEAL_ON_LOAD;
              end else begin
                perr_d = 1'b1;
              end
            end
          end else if (idle_cnt_q == IdleW'(TIMEOUT - 1)) begin
            // This idle cycle is the TIMEOUT-th in a row.
            state_d    = StIdle;
            terr_d     = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      key_q      <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      valid_q    <= 1'b0;
      sealed_q   <= 1'b0;
      perr_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      key_q      <= key_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      valid_q    <= valid_d;
      sealed_q   <= sealed_d;
      perr_q     <= perr_d;
      terr_q     <= terr_d;
    end
  end

  assign ready       = (state_q == StIdle) && !sealed_q;
  assign busy        = (state_q != StIdle);
  assign key_out     = key_q;
  assign key_valid   = valid_q;
  assign sealed      = sealed_q;
  assign parity_err  = perr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Bench for rll_key_loader: a sealing and a non-sealing instance share one stimulus
// stream; a frame-level model predicts output events into per-instance queues and a
// monitor pops and compares them whenever an instance shows an event.
module tb_rll_key_loader;

  localparam int KW = 16;
  localparam int TO = 12;

  typedef enum logic [1:0] {EvUpd, EvPerr, EvTout} ev_kind_e;
  typedef struct {
    ev_kind_e      kind;
    logic [KW-1:0] key;
    logic          valid;
    logic          sealed;
  } ev_t;

  logic clk;
  logic rst, zeroize, load_start, bit_valid, bit_data;
  logic          ready       [2];
  logic          busy        [2];
  logic [KW-1:0] key_out     [2];
  logic          key_valid   [2];
  logic          sealed      [2];
  logic          parity_err  [2];
  logic          timeout_err [2];

  int n_cmp;
  int n_bad;
  bit mon_en;

  ev_t exp_q0[$];
  ev_t exp_q1[$];

  // Reference model state per instance (index 0 seals on load, 1 does not)
  logic [KW-1:0] m_key    [2];
  logic [KW-1:0] m_acc    [2];
  bit            m_valid  [2];
  bit            m_sealed [2];
  bit            m_active [2];
  int            m_n      [2];
  int            m_idle   [2];

  rll_key_loader #(.KEY_WIDTH(KW), .TIMEOUT(TO), .SEAL_ON_LOAD(1'b1)) dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .load_start(load_start),
    .bit_valid(bit_valid), .bit_data(bit_data), .ready(ready[0]), .busy(busy[0]),
    .key_out(key_out[0]), .key_valid(key_valid[0]), .sealed(sealed[0]),
    .parity_err(parity_err[0]), .timeout_err(timeout_err[0])
  );

  rll_key_loader #(.KEY_WIDTH(KW), .TIMEOUT(TO), .SEAL_ON_LOAD(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .zeroize(zeroize), .load_start(load_start),
    .bit_valid(bit_valid), .bit_data(bit_data), .ready(ready[1]), .busy(busy[1]),
    .key_out(key_out[1]), .key_valid(key_valid[1]), .sealed(sealed[1]),
    .parity_err(parity_err[1]), .timeout_err(timeout_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int d, input ev_kind_e k, input logic [KW-1:0] key,
                         input logic v, input logic s);
    ev_t e;
    e.kind = k; e.key = key; e.valid = v; e.sealed = s;
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic expect_ev(input int d, input ev_kind_e k, input logic [KW-1:0] key,
                           input logic v, input logic s);
    ev_t e;
    int  sz;
    n_cmp++;
    sz = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      n_bad++;
      $display("FAIL sb%0d_unexpected: got event %0d key %h v %0b s %0b, want none",
               d, k, key, v, s);
      return;
    end
    if (d == 0) e = exp_q0.pop_front();
    else e = exp_q1.pop_front();
    if (e.kind !== k || (k == EvUpd && {key, v, s} !== {e.key, e.valid, e.sealed})) begin
      n_bad++;
      $display("FAIL sb%0d_event: got %0d key %h v %0b s %0b want %0d key %h v %0b s %0b",
               d, k, key, v, s, e.kind, e.key, e.valid, e.sealed);
    end
  endtask

  // Frame-level model: applies one cycle of inputs and predicts the resulting events.
  task automatic model_step(input int d, input bit r, input bit z, input bit ls,
                            input bit bv, input bit bd);
    logic [KW-1:0] pk = m_key[d];
    bit pv = m_valid[d];
    bit ps = m_sealed[d];
    if (r || z) begin
      m_key[d] = '0; m_valid[d] = 0; m_sealed[d] = 0; m_active[d] = 0;
    end else if (!m_active[d]) begin
      if (ls && !m_sealed[d]) begin
        m_active[d] = 1; m_n[d] = 0; m_acc[d] = '0; m_idle[d] = 0;
      end
    end else if (ls) begin
      m_n[d] = 0; m_acc[d] = '0; m_idle[d] = 0;
    end else if (bv) begin
      m_idle[d] = 0;
      if (m_n[d] < KW) begin
        m_acc[d] = KW'(m_acc[d] * 2 + {15'd0, bd});
        m_n[d]++;
      end else begin
        m_active[d] = 0;
        if ((($countones(m_acc[d]) + int'(bd)) % 2) == 0) begin
          m_key[d] = m_acc[d]; m_valid[d] = 1; m_sealed[d] = (d == 0);
        end else begin
          push_ev(d, EvPerr, '0, 1'b0, 1'b0);
        end
      end
    end else begin
      m_idle[d]++;
      if (m_idle[d] == TO) begin
        m_active[d] = 0;
        push_ev(d, EvTout, '0, 1'b0, 1'b0);
      end
    end
    if (pk != m_key[d] || pv != m_valid[d] || ps != m_sealed[d])
      push_ev(d, EvUpd, m_key[d], m_valid[d], m_sealed[d]);
  endtask

  // One clock of stimulus; returns at the following falling edge.
  task automatic step(input bit r, input bit z, input bit ls, input bit bv, input bit bd);
    rst = r; zeroize = z; load_start = ls; bit_valid = bv; bit_data = bd;
    model_step(0, r, z, ls, bv, bd);
    model_step(1, r, z, ls, bv, bd);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("ready%0d", d), 32'(ready[d]), 32'(!m_active[d] && !m_sealed[d]));
      check($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_active[d]));
    end
  endtask

  task automatic gaps(input int max_gap);
    int n;
    n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(1, 0)));
  endtask

  task automatic send_frame(input logic [KW-1:0] k, input bit par, input int max_gap);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = KW - 1; i >= 0; i--) begin
      gaps(max_gap);
      step(1'b0, 1'b0, 1'b0, 1'b1, k[i]);
    end
    gaps(max_gap);
    step(1'b0, 1'b0, 1'b0, 1'b1, par);
  endtask

  // Monitor: any pulse or change of the applied key state must match the next prediction.
  initial begin
    logic [KW-1:0] last_key [2];
    logic          last_v   [2];
    logic          last_s   [2];
    for (int d = 0; d < 2; d++) begin
      last_key[d] = '0; last_v[d] = 1'b0; last_s[d] = 1'b0;
    end
    wait (mon_en);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (parity_err[d] !== 1'b0) expect_ev(d, EvPerr, '0, 1'b0, 1'b0);
        if (timeout_err[d] !== 1'b0) expect_ev(d, EvTout, '0, 1'b0, 1'b0);
        if ({key_out[d], key_valid[d], sealed[d]} !== {last_key[d], last_v[d], last_s[d]}) begin
          expect_ev(d, EvUpd, key_out[d], key_valid[d], sealed[d]);
          last_key[d] = key_out[d]; last_v[d] = key_valid[d]; last_s[d] = sealed[d];
        end
      end
    end
  end

  initial begin
    int tcnt;
    logic [KW-1:0] k;
    bit par;
    n_cmp = 0; n_bad = 0; mon_en = 0;
    rst = 1; zeroize = 0; load_start = 0; bit_valid = 0; bit_data = 0;
    for (int d = 0; d < 2; d++) begin
      m_key[d] = '0; m_acc[d] = '0; m_valid[d] = 0; m_sealed[d] = 0;
      m_active[d] = 0; m_n[d] = 0; m_idle[d] = 0;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_key%0d", d), 32'(key_out[d]), 32'h0);
      check($sformatf("rst_valid%0d", d), 32'(key_valid[d]), 32'h0);
      check($sformatf("rst_sealed%0d", d), 32'(sealed[d]), 32'h0);
      check($sformatf("rst_perr%0d", d), 32'(parity_err[d]), 32'h0);
      check($sformatf("rst_terr%0d", d), 32'(timeout_err[d]), 32'h0);
    end
    mon_en = 1;

    // T1: clean load seals
    send_frame(16'hA5C3, 1'b0, 0);
    check("t1_key", 32'(key_out[0]), 32'hA5C3);
    check("t1_valid", 32'(key_valid[0]), 32'h1);
    check("t1_sealed", 32'(sealed[0]), 32'h1);
    check("t1_ready", 32'(ready[0]), 32'h0);

    // T2: bad parity from reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(16'h0001, 1'b0, 2);
    check("t2_perr", 32'(parity_err[0]), 32'h1);
    check("t2_key", 32'(key_out[0]), 32'h0);
    check("t2_valid", 32'(key_valid[0]), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_perr_one_cycle", 32'(parity_err[0]), 32'h0);

    // T3: sealed key ignores a new frame; zeroize clears
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(16'hA5C3, 1'b0, 1);
    send_frame(16'h1234, 1'b1, 1);
    check("t3_key_kept", 32'(key_out[0]), 32'hA5C3);
    check("t3_unsealed_took", 32'(key_out[1]), 32'h1234);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_zero_key", 32'(key_out[0]), 32'h0);
    check("t3_zero_sealed", 32'(sealed[0]), 32'h0);
    check("t3_zero_ready", 32'(ready[0]), 32'h1);

    // T4: stall after 7 bits times out on the unsealed instance
    send_frame(16'h3C3C, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(1, 0)));
    tcnt = 0;
    for (int i = 1; i <= TO + 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (timeout_err[1] === 1'b1) tcnt++;
      if (i == TO - 1) check("t4_busy_before", 32'(busy[1]), 32'h1);
      if (i == TO) check("t4_terr_at", 32'(timeout_err[1]), 32'h1);
    end
    check("t4_terr_count", 32'(tcnt), 32'd1);
    check("t4_key_held", 32'(key_out[1]), 32'h3C3C);
    check("t4_busy_after", 32'(busy[1]), 32'h0);

    // T5: restart after 9 bits, then reset mid-frame
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(1, 0)));
    send_frame(16'h8000, 1'b1, 1);
    check("t5_key", 32'(key_out[0]), 32'h8000);
    check("t5_valid", 32'(key_valid[0]), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t5_rst_key%0d", d), 32'(key_out[d]), 32'h0);
      check($sformatf("t5_rst_valid%0d", d), 32'(key_valid[d]), 32'h0);
      check($sformatf("t5_rst_sealed%0d", d), 32'(sealed[d]), 32'h0);
    end

    // T6: reload permitted without sealing
    send_frame(16'hFFFF, 1'b0, 1);
    send_frame(16'h00FF, 1'b0, 1);
    check("t6_key", 32'(key_out[1]), 32'h00FF);
    check("t6_sealed", 32'(sealed[1]), 32'h0);
    check("t6_sealed_kept", 32'(key_out[0]), 32'hFFFF);

    // Randomized traffic
    repeat (120) begin
      int r;
      r = int'($urandom_range(9, 0));
      k = KW'($urandom);
      par = (^k) ^ ($urandom_range(3, 0) == 0);
      if (r == 0) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      else if (r == 1) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (r <= 5) send_frame(k, par, int'($urandom_range(3, 0)));
      else if (r == 6) send_frame(k, par, TO + 1);
      else begin
        repeat (20) step(1'b0, ($urandom_range(30, 0) == 0), ($urandom_range(15, 0) == 0),
                         1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
    end

    repeat (TO + 4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("sb0_drained", 32'(exp_q0.size()), 32'd0);
    check("sb1_drained", 32'(exp_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
